// File: rtl/pc_gen.sv
// Registered program counter for the fetch stage: picks trap, redirect, hold or sequential step each cycle.
// Latency 1 cycle; misaligned redirects are rejected (PC holds) and reported through misaligned/bad_addr.
module pc_gen #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          C_EXT        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            inst_compressed,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_link,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  localparam logic [XLEN-1:0] STEP_WORD = XLEN'(4);
  localparam logic [XLEN-1:0] STEP_HALF = XLEN'(2);
  localparam logic [XLEN-1:0] LOW2_MASK = XLEN'(3);

  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_misaligned;
  logic [XLEN-1:0] r_bad_addr;

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_pc_step;
  logic [XLEN-1:0] w_trap_pc;
  logic            w_target_misaligned;

  // With C_EXT=0 the compressed hint is meaningless and the step is always a word.
  assign w_step    = ((C_EXT != 0) && inst_compressed) ? STEP_HALF : STEP_WORD;
  assign w_pc_step = r_pc + w_step;
  assign w_trap_pc = trap_vector & ~LOW2_MASK;

  assign w_target_misaligned = (C_EXT != 0) ? redirect_target[0]
                                            : (|redirect_target[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_VECTOR;
      r_pc_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      r_bad_addr   <= '0;
    end else if (!r_pc_valid) begin
      // First edge out of reset only validates RESET_VECTOR as the first fetch.
      r_pc_valid   <= 1'b1;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      if (trap_valid) begin
        r_pc <= w_trap_pc;
      end else if (redirect_valid) begin
        if (w_target_misaligned) begin
          r_misaligned <= 1'b1;
          r_bad_addr   <= redirect_target;
        end else begin
          r_pc <= redirect_target;
        end
      end else if (!stall) begin
        r_pc <= w_pc_step;
      end
    end
  end

  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign pc_link    = w_pc_step;
  assign misaligned = r_misaligned;
  assign bad_addr   = r_bad_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one word-only instance and one compressed-capable instance share stimulus.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        inst_compressed;

  logic [31:0] pc0, link0, bad0;
  logic        vld0, mis0;
  logic [31:0] pc1, link1, bad1;
  logic        vld1, mis1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .inst_compressed(inst_compressed),
    .pc(pc0), .pc_valid(vld0), .pc_link(link0), .misaligned(mis0), .bad_addr(bad0)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .inst_compressed(inst_compressed),
    .pc(pc1), .pc_valid(vld1), .pc_link(link1), .misaligned(mis1), .bad_addr(bad1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    redirect_target = 32'h0; trap_vector = 32'h0; inst_compressed = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1; redirect_target = tgt;
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_pc", pc0, 32'h0);
    chk("rst_vld", 32'(vld0), 32'h0);
    chk("rst_mis", 32'(mis0), 32'h0);
    chk("rst_bad", bad0, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("pre_edge_vld", 32'(vld0), 32'h0);
    tick(); chk("vld_rise", 32'(vld0), 32'h1); chk("pc_a", pc0, 32'h0); chk("link_a", link0, 32'h4);
    tick(); chk("pc_b", pc0, 32'h4); chk("link_b", link0, 32'h8);
    tick(); chk("pc_c", pc0, 32'h8); chk("link_c", link0, 32'hC);

    redirect(32'h100);
    chk("redir_100", pc0, 32'h100);
    stall = 1'b1;
    tick(); chk("stall_1", pc0, 32'h100);
    tick(); chk("stall_2", pc0, 32'h100);
    redirect_valid = 1'b1; redirect_target = 32'h0010_7600;
    tick(); chk("flush_over_stall", pc0, 32'h0010_7600);
    idle();
    tick(); chk("after_flush", pc0, 32'h0010_7604);

    redirect(32'h20);
    chk("redir_20", pc0, 32'h20);
    redirect(32'h42);
    chk("mis_hold_pc", pc0, 32'h20);
    chk("mis_flag", 32'(mis0), 32'h1);
    chk("mis_bad", bad0, 32'h42);
    tick();
    chk("mis_next_pc", pc0, 32'h24);
    chk("mis_pulse_end", 32'(mis0), 32'h0);
    chk("bad_kept", bad0, 32'h42);

    redirect_valid = 1'b1; redirect_target = 32'h41;
    tick(); chk("b2b_mis1", 32'(mis0), 32'h1); chk("b2b_bad1", bad0, 32'h41);
    redirect_target = 32'h43;
    tick(); chk("b2b_mis2", 32'(mis0), 32'h1); chk("b2b_bad2", bad0, 32'h43);
    chk("b2b_pc", pc0, 32'h24);
    idle();

    trap_valid = 1'b1; trap_vector = 32'h8000_0003;
    redirect_valid = 1'b1; redirect_target = 32'h200; stall = 1'b1;
    tick(); chk("trap_pc", pc0, 32'h8000_0000); chk("trap_mis", 32'(mis0), 32'h0);
    trap_vector = 32'h1000; redirect_target = 32'h46; stall = 1'b0;
    tick(); chk("trap_vs_mis_pc", pc0, 32'h1000);
    chk("trap_vs_mis_flag", 32'(mis0), 32'h0);
    chk("trap_vs_mis_bad", bad0, 32'h43);
    idle();

    redirect(32'hFFFF_FFF8);
    chk("wrap_start", pc0, 32'hFFFF_FFF8);
    tick(); chk("wrap_1", pc0, 32'hFFFF_FFFC); chk("wrap_link", link0, 32'h0);
    tick(); chk("wrap_2", pc0, 32'h0);
    tick(); chk("wrap_3", pc0, 32'h4);

    redirect(32'h10);
    chk("c_start", pc1, 32'h10);
    inst_compressed = 1'b1;
    #1 chk("c_link_comb", link1, 32'h12);
    chk("c0_link_ignores", link0, 32'h14);
    tick(); chk("c_pc1", pc1, 32'h12);
    tick(); chk("c_pc2", pc1, 32'h14);
    inst_compressed = 1'b0;
    tick(); chk("c_pc3", pc1, 32'h18);
    redirect(32'h102);
    chk("c_redir_ok", pc1, 32'h102); chk("c_redir_nomis", 32'(mis1), 32'h0);
    redirect(32'h103);
    chk("c_mis_pc", pc1, 32'h102); chk("c_mis_flag", 32'(mis1), 32'h1);
    chk("c_mis_bad", bad1, 32'h103);
    tick(); chk("c_after_mis", pc1, 32'h106);

    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc1, 32'h0);
    chk("async_rst_vld", 32'(vld1), 32'h0);
    chk("async_rst_bad", bad1, 32'h0);
    redirect_valid = 1'b1; redirect_target = 32'h300; stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("ignore_ctl_pc", pc1, 32'h0); chk("ignore_ctl_vld", 32'(vld1), 32'h1);
    idle();
    tick(); chk("post_rst_step", pc1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
